// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions: datapath widths, op codes and the result-stage occupancy states.
package alu_result_stage_pkg;

    localparam int unsigned ALU_W   = 32;
    localparam int unsigned ALU_OPW = 4;

    typedef enum logic [ALU_OPW-1:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_NOR = 4'd2,
        ALU_ADD = 4'd3,
        ALU_SUB = 4'd4,
        ALU_SLT = 4'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// Valid/ready result bus carrying an ALU result and the op code that produced it.
interface alu_result_stage_if #(
    parameter int unsigned W   = 32,
    parameter int unsigned OPW = 4
);
    logic           valid;
    logic           ready;
    logic [W-1:0]   res;
    logic [OPW-1:0] op;

    modport master (output valid, output res, output op, input ready);
    modport slave  (input valid, input res, input op, output ready);
endinterface

// File: rtl/alu_result_stage_flag_gen.sv
// Zero/negative flag derivation for a result word.
module alu_flag_gen #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] res,
    output logic         zero,
    output logic         neg
);
    assign zero = (res == '0);
    assign neg  = res[W-1];
endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: two-entry skid buffer with capture-time flags and an emit counter.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned W   = ALU_W,
    parameter int unsigned OPW = ALU_OPW,
    parameter int unsigned CW  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    alu_result_stage_if.slave       in_bus,
    alu_result_stage_if.master      out_bus,
    output logic                    out_zero,
    output logic                    out_neg,
    output logic [CW-1:0]           out_cnt
);
    occ_state_e     state, state_nxt;
    logic           in_ready_q, out_valid_q;
    logic [W-1:0]   main_res, skid_res;
    logic [OPW-1:0] main_op, skid_op;
    logic           main_zero, main_neg, skid_zero, skid_neg;
    logic           cap_zero, cap_neg;
    logic           accept, emit;
    logic           load_main_in, load_main_skid, load_skid;

    alu_flag_gen #(.W(W)) u_flag_gen (
        .res  (in_bus.res),
        .zero (cap_zero),
        .neg  (cap_neg)
    );

    assign accept = in_bus.valid & in_ready_q;
    assign emit   = out_valid_q & out_bus.ready;

    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            ST_EMPTY: if (accept) begin
                state_nxt    = ST_ONE;
                load_main_in = 1'b1;
            end
            ST_ONE: begin
                if (accept && emit) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_TWO;
                    load_skid = 1'b1;
                end else if (emit) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: if (emit) begin
                state_nxt      = ST_ONE;
                load_main_skid = 1'b1;
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush wins over any same-cycle capture; the emit itself is still counted below.
        if (flush) begin
            state_nxt      = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Handshake outputs are registered from the next state so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_cnt     <= '0;
        end else begin
            in_ready_q  <= (state_nxt != ST_TWO);
            out_valid_q <= (state_nxt != ST_EMPTY);
            out_cnt     <= out_cnt + CW'(emit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            main_res  <= '0;
            main_op   <= '0;
            main_zero <= 1'b0;
            main_neg  <= 1'b0;
            skid_res  <= '0;
            skid_op   <= '0;
            skid_zero <= 1'b0;
            skid_neg  <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_res  <= in_bus.res;
                main_op   <= in_bus.op;
                main_zero <= cap_zero;
                main_neg  <= cap_neg;
            end else if (load_main_skid) begin
                main_res  <= skid_res;
                main_op   <= skid_op;
                main_zero <= skid_zero;
                main_neg  <= skid_neg;
            end
            if (load_skid) begin
                skid_res  <= in_bus.res;
                skid_op   <= in_bus.op;
                skid_zero <= cap_zero;
                skid_neg  <= cap_neg;
            end
        end
    end

    assign in_bus.ready  = in_ready_q;
    assign out_bus.valid = out_valid_q;
    assign out_bus.res   = main_res;
    assign out_bus.op    = main_op;
    assign out_zero      = main_zero;
    assign out_neg       = main_neg;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and scoreboard checks of alu_result_stage (default CW and a CW=4 instance for wrap).
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    logic flush, flush2;
    logic zero_a, neg_a, zero_b, neg_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_result_stage_if #(.W(32), .OPW(4)) a_in ();
    alu_result_stage_if #(.W(32), .OPW(4)) a_out ();
    alu_result_stage_if #(.W(32), .OPW(4)) b_in ();
    alu_result_stage_if #(.W(32), .OPW(4)) b_out ();

    alu_result_stage #(.W(32), .OPW(4), .CW(16)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_bus(a_in.slave), .out_bus(a_out.master),
        .out_zero(zero_a), .out_neg(neg_a), .out_cnt(cnt_a)
    );

    alu_result_stage #(.W(32), .OPW(4), .CW(4)) dut_wrap (
        .clk(clk), .rstn(rstn), .flush(flush2),
        .in_bus(b_in.slave), .out_bus(b_out.master),
        .out_zero(zero_b), .out_neg(neg_b), .out_cnt(cnt_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; flush = 1'b0; flush2 = 1'b0;
        a_in.valid = 1'b1; a_in.res = 32'hdead_beef; a_in.op = 4'(ALU_ADD); a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.res = '0; b_in.op = '0; b_out.ready = 1'b0;
        repeat (3) tick();
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_out.valid); end
        checks++; if (a_in.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", a_in.ready); end
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_a); end
        checks++; if ({a_out.res, a_out.op, zero_a, neg_a} !== '0) begin errors++; $display("FAIL reset_data: got %h/%h/%b%b expected zeros", a_out.res, a_out.op, zero_a, neg_a); end
        rstn = 1'b1; a_in.valid = 1'b0;
        tick();
        checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", a_in.ready); end
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b expected 0", a_out.valid); end
    endtask

    task automatic test_single;
        a_out.ready = 1'b1;
        a_in.valid = 1'b1; a_in.res = 32'h0000_0000; a_in.op = 4'(ALU_NOR);
        tick();
        a_in.valid = 1'b0;
        checks++; if ({a_out.valid, zero_a, neg_a} !== 3'b110) begin errors++; $display("FAIL single_flags: got v/z/n=%b%b%b expected 110", a_out.valid, zero_a, neg_a); end
        checks++; if (a_out.res !== 32'h0 || a_out.op !== 4'(ALU_NOR)) begin errors++; $display("FAIL single_data: got %h/%h expected 00000000/%h", a_out.res, a_out.op, 4'(ALU_NOR)); end
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL single_cnt0: got %0d expected 0", cnt_a); end
        tick();
        exp_cnt++;
        checks++; if (cnt_a !== 16'(exp_cnt)) begin errors++; $display("FAIL single_cnt1: got %0d expected %0d", cnt_a, exp_cnt); end
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", a_out.valid); end
    endtask

    task automatic test_skid;
        a_out.ready = 1'b0;
        a_in.valid = 1'b1; a_in.res = 32'h8000_0001; a_in.op = 4'(ALU_SUB);
        tick();
        a_in.res = 32'h0000_0005; a_in.op = 4'(ALU_ADD);
        tick();
        a_in.valid = 1'b0; a_in.res = 32'hffff_ffff;
        checks++; if (a_in.ready !== 1'b0) begin errors++; $display("FAIL skid_ready: got %b expected 0", a_in.ready); end
        checks++; if (a_out.res !== 32'h8000_0001 || neg_a !== 1'b1 || zero_a !== 1'b0) begin errors++; $display("FAIL skid_head: got %h n=%b z=%b expected 80000001 n=1 z=0", a_out.res, neg_a, zero_a); end
        tick();
        checks++; if (a_out.valid !== 1'b1 || a_out.res !== 32'h8000_0001 || a_out.op !== 4'(ALU_SUB)) begin errors++; $display("FAIL skid_stable: got v=%b %h/%h expected 1 80000001/%h", a_out.valid, a_out.res, a_out.op, 4'(ALU_SUB)); end
        a_out.ready = 1'b1;
        tick();
        exp_cnt++;
        checks++; if (a_out.res !== 32'h5 || a_out.op !== 4'(ALU_ADD) || neg_a !== 1'b0 || zero_a !== 1'b0) begin errors++; $display("FAIL skid_second: got %h/%h n=%b z=%b expected 00000005/%h n=0 z=0", a_out.res, a_out.op, neg_a, zero_a, 4'(ALU_ADD)); end
        checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL skid_reopen: got %b expected 1", a_in.ready); end
        tick();
        exp_cnt++;
        checks++; if (a_out.valid !== 1'b0 || cnt_a !== 16'(exp_cnt)) begin errors++; $display("FAIL skid_drain: got v=%b cnt=%0d expected v=0 cnt=%0d", a_out.valid, cnt_a, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        a_out.ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a_in.valid = 1'b1; a_in.res = 32'(i); a_in.op = 4'(i);
            tick();
            if (i > 0) exp_cnt++;
            checks++; if (a_out.valid !== 1'b1 || a_out.res !== 32'(i) || a_in.ready !== 1'b1) begin errors++; $display("FAIL b2b_beat%0d: got v=%b res=%h rdy=%b expected v=1 res=%h rdy=1", i, a_out.valid, a_out.res, a_in.ready, 32'(i)); end
            checks++; if (cnt_a !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt%0d: got %0d expected %0d", i, cnt_a, exp_cnt); end
        end
        a_in.valid = 1'b0;
        tick();
        exp_cnt++;
        checks++; if (a_out.valid !== 1'b0 || cnt_a !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_drain: got v=%b cnt=%0d expected v=0 cnt=%0d", a_out.valid, cnt_a, exp_cnt); end
    endtask

    task automatic test_flush;
        a_out.ready = 1'b0;
        a_in.valid = 1'b1; a_in.res = 32'h11; tick();
        a_in.res = 32'h22; tick();
        flush = 1'b1; a_in.res = 32'h7;
        tick();
        flush = 1'b0; a_in.valid = 1'b0;
        checks++; if (a_out.valid !== 1'b0 || a_in.ready !== 1'b1 || cnt_a !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_two: got v=%b rdy=%b cnt=%0d expected v=0 rdy=1 cnt=%0d", a_out.valid, a_in.ready, cnt_a, exp_cnt); end
        a_out.ready = 1'b1;
        repeat (2) tick();
        checks++; if (a_out.valid !== 1'b0 || cnt_a !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_no_emit: got v=%b cnt=%0d expected v=0 cnt=%0d", a_out.valid, cnt_a, exp_cnt); end
        a_out.ready = 1'b0;
        a_in.valid = 1'b1; a_in.res = 32'h33; tick();
        flush = 1'b1; a_in.res = 32'h7;
        tick();
        flush = 1'b0; a_in.valid = 1'b0; a_out.ready = 1'b1;
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL flush_beats_accept: got v=%b res=%h expected v=0", a_out.valid, a_out.res); end
        tick();
        checks++; if (a_out.valid !== 1'b0 || cnt_a !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_discard: got v=%b cnt=%0d expected v=0 cnt=%0d", a_out.valid, cnt_a, exp_cnt); end
        a_in.valid = 1'b1; a_in.res = 32'h44; a_out.ready = 1'b0; tick();
        a_in.valid = 1'b0; a_out.ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_cnt++;
        checks++; if (a_out.valid !== 1'b0 || cnt_a !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_emit_counts: got v=%b cnt=%0d expected v=0 cnt=%0d", a_out.valid, cnt_a, exp_cnt); end
    endtask

    task automatic test_reset_mid;
        a_out.ready = 1'b0;
        a_in.valid = 1'b1; a_in.res = 32'h55; tick();
        a_in.res = 32'h66; tick();
        rstn = 1'b0; a_out.ready = 1'b1;
        tick();
        rstn = 1'b1; a_in.valid = 1'b0;
        exp_cnt = 0;
        checks++; if (a_out.valid !== 1'b0 || a_in.ready !== 1'b0 || cnt_a !== 16'd0 || a_out.res !== 32'h0) begin errors++; $display("FAIL mid_reset: got v=%b rdy=%b cnt=%0d res=%h expected 0/0/0/0", a_out.valid, a_in.ready, cnt_a, a_out.res); end
        tick();
        checks++; if (a_out.valid !== 1'b0 || a_in.ready !== 1'b1) begin errors++; $display("FAIL mid_reset_release: got v=%b rdy=%b expected v=0 rdy=1", a_out.valid, a_in.ready); end
    endtask

    task automatic test_wrap;
        logic [31:0] q_res[$];
        logic [3:0]  q_op[$];
        logic [31:0] er;
        logic [3:0]  eo;
        logic acc, emt;
        int emits;
        b_out.ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            b_in.valid = 1'b1; b_in.res = 32'(i + 1); b_in.op = 4'(i);
            tick();
        end
        b_in.valid = 1'b0;
        checks++; if (cnt_b !== 4'd0) begin errors++; $display("FAIL wrap_16: got %0d expected 0", cnt_b); end
        tick();
        checks++; if (cnt_b !== 4'd1) begin errors++; $display("FAIL wrap_17: got %0d expected 1", cnt_b); end
        emits = 17;
        for (int c = 0; c < 10000; c++) begin
            b_in.valid = 1'($urandom_range(0, 1));
            b_in.res = b_in.valid ? (($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom)) : 'x;
            b_in.op = b_in.valid ? 4'($urandom) : 'x;
            b_out.ready = ($urandom_range(0, 3) != 0);
            acc = b_in.valid && b_in.ready;
            emt = b_out.valid && b_out.ready;
            if (emt) begin
                checks++;
                if (q_res.size() == 0) begin
                    errors++; $display("FAIL rand_dup: cycle %0d got %h expected no entry", c, b_out.res);
                end else begin
                    er = q_res.pop_front(); eo = q_op.pop_front();
                    if (b_out.res !== er || b_out.op !== eo || zero_b !== (er == 32'h0) || neg_b !== er[31]) begin
                        errors++; $display("FAIL rand_order: cycle %0d got %h/%h z=%b n=%b expected %h/%h", c, b_out.res, b_out.op, zero_b, neg_b, er, eo);
                    end
                end
                emits++;
            end
            if (acc) begin q_res.push_back(b_in.res); q_op.push_back(b_in.op); end
            tick();
        end
        b_in.valid = 1'b0; b_out.ready = 1'b1;
        for (int d = 0; d < 8 && b_out.valid === 1'b1; d++) begin
            checks++;
            if (q_res.size() == 0) begin
                errors++; $display("FAIL drain_dup: got %h expected no entry", b_out.res);
            end else begin
                er = q_res.pop_front(); eo = q_op.pop_front();
                if (b_out.res !== er || b_out.op !== eo) begin errors++; $display("FAIL drain_order: got %h/%h expected %h/%h", b_out.res, b_out.op, er, eo); end
            end
            emits++;
            tick();
        end
        checks++; if (q_res.size() != 0 || b_out.valid !== 1'b0) begin errors++; $display("FAIL rand_loss: got %0d pending v=%b expected 0 pending v=0", q_res.size(), b_out.valid); end
        checks++; if (cnt_b !== 4'(emits)) begin errors++; $display("FAIL rand_cnt: got %0d expected %0d", cnt_b, 4'(emits)); end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: got no finish expected finish within 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_skid();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
